// File: rtl/comparator_arbiter_if.sv
// Request/response bundle for comparator_arbiter: two requester ports and one response port.
// The master modport is the issue/consumer side; the slave modport is the arbiter.
interface comparator_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned TAG_W  = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [OP_W-1:0]   req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [TAG_W-1:0]  req1_tag;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_src;
    logic [TAG_W-1:0]  rsp_tag;
    logic              rsp_con_met;
    logic [DATA_W-1:0] rsp_out;
    logic              rsp_err;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_src, rsp_tag, rsp_con_met, rsp_out, rsp_err,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_src, rsp_tag, rsp_con_met, rsp_out, rsp_err,
        input  rsp_ready
    );
endinterface

// File: rtl/comparator_arbiter.sv
// Round-robin sharing of one branch/SLT comparator between two requesters,
// with a single registered response stage that sustains one op per clock.
module comparator_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 5,
    parameter int unsigned TAG_W  = 4
) (
    input logic clk,
    input logic rst,
    comparator_arbiter_if.slave bus
);
    localparam logic [OP_W-1:0] OpBeq  = OP_W'(0);
    localparam logic [OP_W-1:0] OpBne  = OP_W'(1);
    localparam logic [OP_W-1:0] OpBlt  = OP_W'(2);
    localparam logic [OP_W-1:0] OpBge  = OP_W'(3);
    localparam logic [OP_W-1:0] OpBltu = OP_W'(4);
    localparam logic [OP_W-1:0] OpBgeu = OP_W'(5);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(9);
    localparam logic [OP_W-1:0] OpSltu = OP_W'(10);

    logic              last_grant_q, last_grant_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_src_q, rsp_src_d;
    logic [TAG_W-1:0]  rsp_tag_q, rsp_tag_d;
    logic              rsp_con_met_q, rsp_con_met_d;
    logic [DATA_W-1:0] rsp_out_q, rsp_out_d;
    logic              rsp_err_q, rsp_err_d;

    logic              grant0, grant1, can_accept, accept;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    logic [TAG_W-1:0]  sel_tag;
    logic              cmp_eq, cmp_lt_s, cmp_lt_u;
    logic              cmp_con_met, cmp_slt, cmp_err;

    // A drain in the same cycle frees the slot, so ready never waits on a bubble.
    always_comb begin
        can_accept = !rsp_valid_q || bus.rsp_ready;
        grant0     = bus.req0_valid && (!bus.req1_valid || last_grant_q);
        grant1     = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
        accept     = (grant0 || grant1) && can_accept;
    end

    assign bus.req0_ready = grant0 && can_accept;
    assign bus.req1_ready = grant1 && can_accept;

    always_comb begin
        sel_op  = grant1 ? bus.req1_op  : bus.req0_op;
        sel_a   = grant1 ? bus.req1_a   : bus.req0_a;
        sel_b   = grant1 ? bus.req1_b   : bus.req0_b;
        sel_tag = grant1 ? bus.req1_tag : bus.req0_tag;
    end

    // Shared comparator
    always_comb begin
        cmp_eq      = (sel_a == sel_b);
        cmp_lt_s    = ($signed(sel_a) < $signed(sel_b));
        cmp_lt_u    = (sel_a < sel_b);
        cmp_con_met = 1'b0;
        cmp_slt     = 1'b0;
        cmp_err     = 1'b0;
        case (sel_op)
            OpBeq:   cmp_con_met = cmp_eq;
            OpBne:   cmp_con_met = !cmp_eq;
            OpBlt:   cmp_con_met = cmp_lt_s;
            OpBge:   cmp_con_met = !cmp_lt_s;
            OpBltu:  cmp_con_met = cmp_lt_u;
            OpBgeu:  cmp_con_met = !cmp_lt_u;
            OpSlt:   cmp_slt     = cmp_lt_s;
            OpSltu:  cmp_slt     = cmp_lt_u;
            default: cmp_err     = 1'b1;
        endcase
    end

    // Data fields hold on a plain drain; only rsp_valid drops.
    always_comb begin
        last_grant_d  = last_grant_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_src_d     = rsp_src_q;
        rsp_tag_d     = rsp_tag_q;
        rsp_con_met_d = rsp_con_met_q;
        rsp_out_d     = rsp_out_q;
        rsp_err_d     = rsp_err_q;
        if (accept) begin
            last_grant_d  = grant1;
            rsp_valid_d   = 1'b1;
            rsp_src_d     = grant1;
            rsp_tag_d     = sel_tag;
            rsp_con_met_d = cmp_con_met;
            rsp_out_d     = {{(DATA_W-1){1'b0}}, cmp_slt};
            rsp_err_d     = cmp_err;
        end else if (bus.rsp_ready) begin
            rsp_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q  <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_src_q     <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_con_met_q <= 1'b0;
            rsp_out_q     <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_src_q     <= rsp_src_d;
            rsp_tag_q     <= rsp_tag_d;
            rsp_con_met_q <= rsp_con_met_d;
            rsp_out_q     <= rsp_out_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_src     = rsp_src_q;
    assign bus.rsp_tag     = rsp_tag_q;
    assign bus.rsp_con_met = rsp_con_met_q;
    assign bus.rsp_out     = rsp_out_q;
    assign bus.rsp_err     = rsp_err_q;
endmodule

// File: tb/tb_comparator_arbiter.sv
// Directed bench for comparator_arbiter: each request carries its hand-computed result,
// an arbitration model predicts grants and queues expected responses for a monitor.
module tb_comparator_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    comparator_arbiter_if #(.DATA_W(32), .OP_W(5), .TAG_W(4)) bus ();

    comparator_arbiter #(.DATA_W(32), .OP_W(5), .TAG_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        src;
        logic [3:0]  tag;
        logic        con;
        logic [31:0] out;
        logic        err;
    } rsp_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  tag;
        logic        con;
        logic        out;
        logic        err;
    } req_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    rsp_t exp_q[$];
    logic exp_valid = 1'b0;
    logic m_last = 1'b1;
    logic rsp_ready_v = 1'b1;
    req_t r0 = '0;
    req_t r1 = '0;
    req_t idle = '0;
    logic acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic req_t mk(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] tag, input logic con, input logic out,
                                input logic err);
        req_t r;
        r = '{valid: 1'b1, op: op, a: a, b: b, tag: tag, con: con, out: out, err: err};
        return r;
    endfunction

    function automatic rsp_t expect_of(input logic src, input req_t r);
        rsp_t e;
        e = '{src: src, tag: r.tag, con: r.con, out: {31'd0, r.out}, err: r.err};
        return e;
    endfunction

    task automatic apply();
        bus.req0_valid = r0.valid; bus.req0_op = r0.op; bus.req0_a = r0.a;
        bus.req0_b = r0.b; bus.req0_tag = r0.tag;
        bus.req1_valid = r1.valid; bus.req1_op = r1.op; bus.req1_a = r1.a;
        bus.req1_b = r1.b; bus.req1_tag = r1.tag;
        bus.rsp_ready = rsp_ready_v;
    endtask

    // One clock: predict grants at the negedge, advance the model at the posedge.
    task automatic step(output logic accepted);
        logic g0, g1, ca, drain;
        g0 = 1'b0; g1 = 1'b0; accepted = 1'b0;
        apply();
        @(negedge clk);
        if (!rst) begin
            g0 = r0.valid && (!r1.valid || m_last);
            g1 = r1.valid && (!r0.valid || !m_last);
            ca = !exp_valid || rsp_ready_v;
            check("req0_ready", {63'd0, bus.req0_ready}, {63'd0, g0 && ca});
            check("req1_ready", {63'd0, bus.req1_ready}, {63'd0, g1 && ca});
            accepted = (g0 || g1) && ca;
            if (accepted) exp_q.push_back(g1 ? expect_of(1'b1, r1) : expect_of(1'b0, r0));
        end
        drain = exp_valid && rsp_ready_v;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_valid = 1'b0;
            m_last    = 1'b1;
        end else if (accepted) begin
            exp_valid = 1'b1;
            m_last    = g1;
        end else if (drain) begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            check("rsp_valid", {63'd0, bus.rsp_valid}, {63'd0, exp_valid});
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    check("rsp_queue_empty", 64'd1, 64'd0);
                end else begin
                    check("rsp_src", {63'd0, bus.rsp_src}, {63'd0, exp_q[0].src});
                    check("rsp_tag", {60'd0, bus.rsp_tag}, {60'd0, exp_q[0].tag});
                    check("rsp_con_met", {63'd0, bus.rsp_con_met}, {63'd0, exp_q[0].con});
                    check("rsp_out", {32'd0, bus.rsp_out}, {32'd0, exp_q[0].out});
                    check("rsp_err", {63'd0, bus.rsp_err}, {63'd0, exp_q[0].err});
                    if (rsp_ready_v) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        apply();
        rst = 1'b1;
        step(acc);
        step(acc);
        rst = 1'b0;
        check("reset_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("reset_rsp_src", {63'd0, bus.rsp_src}, 64'd0);
        check("reset_rsp_tag", {60'd0, bus.rsp_tag}, 64'd0);
        check("reset_rsp_con_met", {63'd0, bus.rsp_con_met}, 64'd0);
        check("reset_rsp_out", {32'd0, bus.rsp_out}, 64'd0);
        check("reset_rsp_err", {63'd0, bus.rsp_err}, 64'd0);

        // 1: single BEQ, 5 == 5
        rsp_ready_v = 1'b1;
        r0 = mk(5'd0, 32'd5, 32'd5, 4'd3, 1'b1, 1'b0, 1'b0);
        step(acc);
        r0 = idle;
        step(acc);

        // 2: contention, BLT -1<1 true, SLTU 0xFFFFFFFF<1 false
        r0 = mk(5'd2, 32'hFFFF_FFFF, 32'd1, 4'd1, 1'b1, 1'b0, 1'b0);
        r1 = mk(5'd10, 32'hFFFF_FFFF, 32'd1, 4'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) step(acc);
        r0 = idle; r1 = idle;
        step(acc);

        // 3: stall with SLT 0x80000000 < 0 pending
        rsp_ready_v = 1'b0;
        r0 = mk(5'd1, 32'd1, 32'd2, 4'd5, 1'b1, 1'b0, 1'b0);
        step(acc);
        r0 = idle;
        r1 = mk(5'd9, 32'h8000_0000, 32'd0, 4'd6, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(acc);
        rsp_ready_v = 1'b1;
        step(acc);
        r1 = idle;
        step(acc);
        step(acc);

        // 4: illegal op 7, then BGEU 0 >= 0
        r1 = mk(5'd7, 32'd0, 32'd0, 4'd7, 1'b0, 1'b0, 1'b1);
        step(acc);
        r1 = mk(5'd5, 32'd0, 32'd0, 4'd8, 1'b1, 1'b0, 1'b0);
        step(acc);
        r1 = idle;
        step(acc);

        // 5: reset while holding a stalled response, then contention favours req0
        rsp_ready_v = 1'b0;
        r0 = mk(5'd0, 32'd1, 32'd2, 4'd9, 1'b0, 1'b0, 1'b0);
        step(acc);
        r0 = idle;
        rst = 1'b1;
        step(acc);
        rst = 1'b0;
        rsp_ready_v = 1'b1;
        r0 = mk(5'd4, 32'd1, 32'd2, 4'd10, 1'b1, 1'b0, 1'b0);
        r1 = mk(5'd9, 32'd2, 32'd1, 4'd11, 1'b0, 1'b0, 1'b0);
        step(acc);
        check("post_reset_first_grant_req0", {63'd0, acc && !m_last}, 64'd1);
        step(acc);
        r0 = idle; r1 = idle;
        step(acc);

        // 6: back-to-back req0, BNE 1,2 true and BGE -1,0 false
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) r0 = mk(5'd1, 32'd1, 32'd2, 4'd12, 1'b1, 1'b0, 1'b0);
            else            r0 = mk(5'd3, 32'hFFFF_FFFF, 32'd0, 4'd13, 1'b0, 1'b0, 1'b0);
            step(acc);
        end
        r0 = idle;
        step(acc);
        step(acc);
        check("scoreboard_drained", {32'd0, exp_q.size()}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
